// File: rtl/mailbox_pkg.sv
// Register map constants for the OBI host/CPU mailbox.
// Shared by the responder top and its testbench-facing decode.
package mailbox_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_CMD    = 2'd1;
    localparam logic [1:0] REG_RSP    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_CMD_VALID_BIT  = 0;
    localparam int ST_FIFO_FULL_BIT  = 1;
    localparam int ST_FIFO_EMPTY_BIT = 2;
    localparam int ST_COUNT_LSB      = 8;

    localparam int CTRL_IRQ_EN_BIT = 0;

    // Byte lanes without an enable are written as zero.
    function automatic logic [31:0] be_mask(input logic [3:0] be, input logic [31:0] d);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = be[i] ? d[i*8 +: 8] : 8'h00;
        return m;
    endfunction

endpackage

// File: rtl/sync_fifo_32.sv
// 32-bit synchronous FIFO with occupancy count; head word is shown combinationally.
// Push when full and pop when empty are both ignored.
module sync_fifo_32 #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [31:0]         push_data,
    input  logic                pop,
    output logic [31:0]         head,
    output logic                full,
    output logic                empty,
    output logic [FIFO_AW:0]    count
);

    logic [31:0]        mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               do_push, do_pop;

    assign full    = (count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obi_mailbox_responder.sv
// OBI responder bridging host commands to the CPU and CPU results back to the host.
// Holds decode, the command slot, CTRL, and the single-cycle registered response.
module obi_mailbox_responder
    import mailbox_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic [31:0] host_cmd_i,
    input  logic        host_cmd_valid_i,
    output logic        host_cmd_ready_o,
    output logic [31:0] host_rsp_data_o,
    output logic        host_rsp_valid_o,
    input  logic        host_rsp_ready_i,
    output logic        irq_o
);

    logic [1:0]         reg_sel;
    logic               cmd_valid, irq_en;
    logic [31:0]        cmd_reg;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FIFO_AW:0]   fifo_count;
    logic [31:0]        status_word, read_word;
    logic               rd_gnt, wr_gnt;
    logic               unused_addr_bits;

    assign reg_sel          = addr_i[3:2];
    assign unused_addr_bits = ^{addr_i[31:4], addr_i[1:0]};

    // Backpressure only the one access that would overflow the FIFO.
    assign gnt_o  = req_i & ~(we_i & (reg_sel == REG_RSP) & fifo_full);
    assign rd_gnt = gnt_o & ~we_i;
    assign wr_gnt = gnt_o & we_i;

    assign fifo_push        = wr_gnt & (reg_sel == REG_RSP);
    assign fifo_pop         = host_rsp_ready_i & ~fifo_empty;
    assign host_rsp_valid_o = ~fifo_empty;
    assign host_cmd_ready_o = ~cmd_valid;
    assign irq_o            = cmd_valid & irq_en;

    always_comb begin
        status_word                    = '0;
        status_word[ST_CMD_VALID_BIT]  = cmd_valid;
        status_word[ST_FIFO_FULL_BIT]  = fifo_full;
        status_word[ST_FIFO_EMPTY_BIT] = fifo_empty;
        status_word[ST_COUNT_LSB +: 8] = 8'(fifo_count);
    end

    always_comb begin
        read_word = '0;
        case (reg_sel)
            REG_STATUS: read_word = status_word;
            REG_CMD:    read_word = cmd_reg;
            REG_CTRL:   read_word[CTRL_IRQ_EN_BIT] = irq_en;
            default:    read_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            cmd_valid <= 1'b0;
            cmd_reg   <= '0;
            irq_en    <= 1'b0;
        end else begin
            rvalid_o <= gnt_o;
            rdata_o  <= rd_gnt ? read_word : '0;

            // Load and clear are mutually exclusive: loading needs the slot empty.
            if (host_cmd_valid_i && !cmd_valid) begin
                cmd_reg   <= host_cmd_i;
                cmd_valid <= 1'b1;
            end else if (rd_gnt && reg_sel == REG_CMD && cmd_valid) begin
                cmd_valid <= 1'b0;
            end

            if (wr_gnt && reg_sel == REG_CTRL && be_i[0])
                irq_en <= wdata_i[CTRL_IRQ_EN_BIT];
        end
    end

    sync_fifo_32 #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (be_mask(be_i, wdata_i)),
        .pop       (fifo_pop),
        .head      (host_rsp_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
